ssp_cfg_sequencer: RTL and testbench
====================================

Name: ssp_cfg_sequencer

Overview:
- PCLK-domain controller for the SSP normal-mode register core's write-enable and write-data interface.
- Arbitrates between host (APB-decoded) register writes and an autonomous configuration sequence.
- The sequence programs the SSP safely: disable SSE, load CR0 and CPSR, wait for each two-buffer handshake, load IMSC and DMACR, clear interrupts, re-enable.
- Holds off CR0/CPSR rewrites until the SSPCLK side has captured the previous value.

Parameters:
ACK_TIMEOUT, 255, max PCLK cycles to wait for an update handshake before abort (1..2^TMO_W-1)
TMO_W, 8, timeout counter width

Ports:
PCLK  in  1  APB clock
PRESETn  in  1  reset; synchronous, active-low
CfgStart  in  1  start-sequence pulse
CfgCR0  in  16  target SSPCR0
CfgCR1  in  7  target SSPCR1 (bit1 = SSE)
CfgCPSR  in  7  target SSPCPSR[7:1]
CfgIMSC  in  4  target SSPIMSC
CfgDMACR  in  2  target SSPDMACR
HostWrReq  in  1  host write request
HostSel  in  3  0 CR0, 1 CR1, 2 CPSR, 3 IMSC, 4 ICR, 5 DMACR, 6-7 invalid
HostWData  in  16  host write data
HostWrGnt  out  1  combinational grant
CR0Update  in  1  CR0 update toggle from register core
CR0UpdateAck  in  1  CR0 capture toggle, already synchronised to PCLK
CPSRUpdate  in  1  CPSR update toggle
CPSRUpdateAck  in  1  CPSR capture toggle, already synchronised
PWDATAIn  out  16  write data to register core
SSPCR0Wr, SSPCR1Wr, SSPCPSRWr, SSPIMSCWr, SSPICRWr, SSPDMACRWr  out  1 each  write strobes
CfgBusy  out  1  sequence in progress
CfgDone  out  1  one-cycle pulse on successful completion
CfgErr  out  1  one-cycle pulse on handshake timeout

Behaviour:
- Reset (PRESETn low at a PCLK edge): all outputs 0, state IDLE, captured config 0, timeout counter 0. Reset mid-sequence aborts with no further strobes; CfgDone and CfgErr are not pulsed.
- Pending flags: Cr0Pend = CR0Update ^ CR0UpdateAck; CpsrPend = CPSRUpdate ^ CPSRUpdateAck.
- All strobes and PWDATAIn are registered.
  - At most one strobe per cycle.
  - A strobe is high for exactly one cycle, one cycle after the grant or state decision.
  - PWDATAIn holds its last value when no strobe is active.
  - Unused PWDATAIn bits are zero.
- Host path:
  - HostWrGnt = HostWrReq & (state==IDLE) & ~CfgStart & ~(HostSel==0 & Cr0Pend) & ~(HostSel==2 & CpsrPend).
  - On grant, the next cycle drives the selected strobe with PWDATAIn=HostWData.
  - HostSel 6/7: granted, no strobe, write dropped.
- Start: CfgStart in IDLE captures all Cfg* inputs and sets CfgBusy next cycle. CfgStart has priority over a same-cycle host request. CfgStart while busy is ignored.
- FSM (one strobe per WR state):
  - IDLE -> CR1_DIS: CR1 = CfgCR1 with bit1 forced to 0.
  - -> CR0_WR: waits while Cr0Pend; then CR0 = CfgCR0.
  - -> CR0_WAIT: leaves when Cr0Pend falls. The first cycle after the write is ignored because the toggle is still propagating.
  - -> CPSR_WR: waits while CpsrPend; CPSR data = {8'h0, CfgCPSR, 1'b0}.
  - -> CPSR_WAIT: same rule as CR0_WAIT.
  - -> IMSC_WR -> DMACR_WR -> ICR_WR (data 16'h0003) -> CR1_EN (CR1 = CfgCR1) -> DONE.
  - DONE pulses CfgDone, clears CfgBusy, returns to IDLE.
- Timeout:
  - Counter clears on entry to each WAIT state or WR-blocked condition and increments each cycle spent waiting.
  - On reaching ACK_TIMEOUT: pulse CfgErr, return to IDLE, clear CfgBusy, no further strobes. SSE stays disabled.
- CfgBusy is high from the cycle after start through the DONE cycle.
- Minimum sequence length with immediate acks: 11 cycles start-to-CfgDone.

Decomposition:
- Shared package: HostSel codes, FSM state enum, ICR clear value 16'h0003, SSE bit index 1.
- One natural sub-module: ssp_upd_tracker. It computes the pending flag and runs the timeout counter per handshake; instantiate it twice, for CR0 and CPSR.

Test Plan:
- Reset then idle: all strobes 0, PWDATAIn=0, CfgBusy=0 for 10 cycles.
- Host write HostSel=3, data 16'h000F, no pending: HostWrGnt same cycle; SSPIMSCWr=1 with PWDATAIn=16'h000F next cycle only.
- CfgStart with CfgCR1=7'h02, CfgCR0=16'h01C7, CfgCPSR=7'h01, acks returned 3 cycles after each toggle:
  - Strobe order CR1(16'h0000), CR0(16'h01C7), CPSR(16'h0002), IMSC, DMACR, ICR(16'h0003), CR1(16'h0002).
  - CfgDone once.
- Cr0Pend held 1, host write HostSel=0: HostWrGnt=0 until ack toggles. Same cycle: a host HostSel=1 request is granted.
- CPSR ack withheld, ACK_TIMEOUT=4: CfgErr pulses after 4 wait cycles. No IMSC/DMACR/ICR/CR1_EN strobes; CfgBusy=0.
- Edge cases:
  - PRESETn low during CR0_WAIT: the next cycle is IDLE with no strobes.
  - CfgStart and HostWrReq in the same cycle: sequence wins, HostWrGnt=0.

Source files
------------

// File: rtl/ssp_cfg_sequencer_pkg.sv
// Shared types and constants for the SSP configuration sequencer.
package ssp_cfg_sequencer_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned CR1_W   = 7;
    localparam int unsigned CPSR_W  = 7;
    localparam int unsigned IMSC_W  = 4;
    localparam int unsigned DMACR_W = 2;
    localparam int unsigned SSE_BIT = 1;

    localparam logic [DATA_W-1:0] ICR_CLEAR = 16'h0003;

    typedef enum logic [SEL_W-1:0] {
        SEL_CR0   = 3'd0,
        SEL_CR1   = 3'd1,
        SEL_CPSR  = 3'd2,
        SEL_IMSC  = 3'd3,
        SEL_ICR   = 3'd4,
        SEL_DMACR = 3'd5
    } host_sel_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CR1_DIS,
        ST_CR0_WR,
        ST_CR0_WAIT,
        ST_CPSR_WR,
        ST_CPSR_WAIT,
        ST_IMSC_WR,
        ST_DMACR_WR,
        ST_ICR_WR,
        ST_CR1_EN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0]  cr0;
        logic [CR1_W-1:0]   cr1;
        logic [CPSR_W-1:0]  cpsr;
        logic [IMSC_W-1:0]  imsc;
        logic [DMACR_W-1:0] dmacr;
    } cfg_t;

    typedef struct packed {
        logic dmacr;
        logic icr;
        logic imsc;
        logic cpsr;
        logic cr1;
        logic cr0;
    } strobe_t;

    // One-hot strobe for a host select code; invalid codes yield no strobe.
    function automatic strobe_t sel_strobe(input logic [SEL_W-1:0] sel);
        strobe_t s;
        s = '0;
        case (sel)
            SEL_CR0:   s.cr0   = 1'b1;
            SEL_CR1:   s.cr1   = 1'b1;
            SEL_CPSR:  s.cpsr  = 1'b1;
            SEL_IMSC:  s.imsc  = 1'b1;
            SEL_ICR:   s.icr   = 1'b1;
            SEL_DMACR: s.dmacr = 1'b1;
            default:   s       = '0;
        endcase
        return s;
    endfunction

    function automatic logic [CR1_W-1:0] sse_clear(input logic [CR1_W-1:0] cr1);
        logic [CR1_W-1:0] r;
        r          = cr1;
        r[SSE_BIT] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/ssp_upd_tracker.sv
// Pending-flag and timeout counter for one two-buffer update handshake.
module ssp_upd_tracker #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned TMO_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic upd_i,
    input  logic ack_i,
    input  logic wait_i,
    output logic pend_c_o,
    output logic timeout_c_o
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    assign pend_c_o = upd_i ^ ack_i;

    // Counter restarts whenever the sequencer stops waiting on this handshake.
    always_comb begin
        cnt_d = '0;
        if (wait_i) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    assign timeout_c_o = wait_i && (cnt_q == TMO_W'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ssp_cfg_sequencer.sv
// Arbitrates host register writes against the autonomous SSP configuration
// sequence and drives the register core write strobes and write data.
module ssp_cfg_sequencer
    import ssp_cfg_sequencer_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned TMO_W       = 8
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        CfgStart,
    input  logic [15:0] CfgCR0,
    input  logic [6:0]  CfgCR1,
    input  logic [6:0]  CfgCPSR,
    input  logic [3:0]  CfgIMSC,
    input  logic [1:0]  CfgDMACR,
    input  logic        HostWrReq,
    input  logic [2:0]  HostSel,
    input  logic [15:0] HostWData,
    output logic        HostWrGnt,
    input  logic        CR0Update,
    input  logic        CR0UpdateAck,
    input  logic        CPSRUpdate,
    input  logic        CPSRUpdateAck,
    output logic [15:0] PWDATAIn,
    output logic        SSPCR0Wr,
    output logic        SSPCR1Wr,
    output logic        SSPCPSRWr,
    output logic        SSPIMSCWr,
    output logic        SSPICRWr,
    output logic        SSPDMACRWr,
    output logic        CfgBusy,
    output logic        CfgDone,
    output logic        CfgErr
);

    state_e            state_q;
    cfg_t              cfg_q;
    strobe_t           stb_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              first_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic cr0_pend;
    logic cr0_tmo;
    logic cr0_wait;
    logic cpsr_pend;
    logic cpsr_tmo;
    logic cpsr_wait;

    // The first WAIT cycle always counts as waiting: the core's toggle is still in flight.
    assign cr0_wait  = ((state_q == ST_CR0_WR)    && cr0_pend) ||
                       ((state_q == ST_CR0_WAIT)  && (first_q || cr0_pend));
    assign cpsr_wait = ((state_q == ST_CPSR_WR)   && cpsr_pend) ||
                       ((state_q == ST_CPSR_WAIT) && (first_q || cpsr_pend));

    ssp_upd_tracker #(.ACK_TIMEOUT(ACK_TIMEOUT), .TMO_W(TMO_W)) u_cr0_trk (
        .clk         (PCLK),
        .rst_n       (PRESETn),
        .upd_i       (CR0Update),
        .ack_i       (CR0UpdateAck),
        .wait_i      (cr0_wait),
        .pend_c_o    (cr0_pend),
        .timeout_c_o (cr0_tmo)
    );

    ssp_upd_tracker #(.ACK_TIMEOUT(ACK_TIMEOUT), .TMO_W(TMO_W)) u_cpsr_trk (
        .clk         (PCLK),
        .rst_n       (PRESETn),
        .upd_i       (CPSRUpdate),
        .ack_i       (CPSRUpdateAck),
        .wait_i      (cpsr_wait),
        .pend_c_o    (cpsr_pend),
        .timeout_c_o (cpsr_tmo)
    );

    assign HostWrGnt = HostWrReq && (state_q == ST_IDLE) && !CfgStart &&
                       !((HostSel == SEL_CR0)  && cr0_pend) &&
                       !((HostSel == SEL_CPSR) && cpsr_pend);

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q  <= ST_IDLE;
            cfg_q    <= '0;
            stb_q    <= '0;
            pwdata_q <= '0;
            first_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            stb_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (CfgStart) begin
                        cfg_q.cr0   <= CfgCR0;
                        cfg_q.cr1   <= CfgCR1;
                        cfg_q.cpsr  <= CfgCPSR;
                        cfg_q.imsc  <= CfgIMSC;
                        cfg_q.dmacr <= CfgDMACR;
                        busy_q      <= 1'b1;
                        state_q     <= ST_CR1_DIS;
                    end else if (HostWrGnt) begin
                        stb_q <= sel_strobe(HostSel);
                        if (HostSel <= SEL_DMACR) begin
                            pwdata_q <= HostWData;
                        end
                    end
                end
                ST_CR1_DIS: begin
                    stb_q.cr1 <= 1'b1;
                    pwdata_q  <= DATA_W'(sse_clear(cfg_q.cr1));
                    state_q   <= ST_CR0_WR;
                end
                ST_CR0_WR: begin
                    if (cr0_tmo) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!cr0_pend) begin
                        stb_q.cr0 <= 1'b1;
                        pwdata_q  <= cfg_q.cr0;
                        first_q   <= 1'b1;
                        state_q   <= ST_CR0_WAIT;
                    end
                end
                ST_CR0_WAIT: begin
                    if (cr0_tmo) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!first_q && !cr0_pend) begin
                        state_q <= ST_CPSR_WR;
                    end
                end
                ST_CPSR_WR: begin
                    if (cpsr_tmo) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!cpsr_pend) begin
                        stb_q.cpsr <= 1'b1;
                        pwdata_q   <= {8'h00, cfg_q.cpsr, 1'b0};
                        first_q    <= 1'b1;
                        state_q    <= ST_CPSR_WAIT;
                    end
                end
                ST_CPSR_WAIT: begin
                    if (cpsr_tmo) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!first_q && !cpsr_pend) begin
                        state_q <= ST_IMSC_WR;
                    end
                end
                ST_IMSC_WR: begin
                    stb_q.imsc <= 1'b1;
                    pwdata_q   <= DATA_W'(cfg_q.imsc);
                    state_q    <= ST_DMACR_WR;
                end
                ST_DMACR_WR: begin
                    stb_q.dmacr <= 1'b1;
                    pwdata_q    <= DATA_W'(cfg_q.dmacr);
                    state_q     <= ST_ICR_WR;
                end
                ST_ICR_WR: begin
                    stb_q.icr <= 1'b1;
                    pwdata_q  <= ICR_CLEAR;
                    state_q   <= ST_CR1_EN;
                end
                ST_CR1_EN: begin
                    stb_q.cr1 <= 1'b1;
                    pwdata_q  <= DATA_W'(cfg_q.cr1);
                    done_q    <= 1'b1;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign PWDATAIn   = pwdata_q;
    assign SSPCR0Wr   = stb_q.cr0;
    assign SSPCR1Wr   = stb_q.cr1;
    assign SSPCPSRWr  = stb_q.cpsr;
    assign SSPIMSCWr  = stb_q.imsc;
    assign SSPICRWr   = stb_q.icr;
    assign SSPDMACRWr = stb_q.dmacr;
    assign CfgBusy    = busy_q;
    assign CfgDone    = done_q;
    assign CfgErr     = err_q;

endmodule

// File: tb/tb_ssp_cfg_sequencer.sv
// Randomized bench for ssp_cfg_sequencer with a register-core handshake model.
module tb_ssp_cfg_sequencer;

    localparam int unsigned TMO = 10;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        CfgStart = 1'b0;
    logic [15:0] CfgCR0 = '0;
    logic [6:0]  CfgCR1 = '0;
    logic [6:0]  CfgCPSR = '0;
    logic [3:0]  CfgIMSC = '0;
    logic [1:0]  CfgDMACR = '0;
    logic        HostWrReq = 1'b0;
    logic [2:0]  HostSel = '0;
    logic [15:0] HostWData = '0;
    logic        HostWrGnt;
    logic        CR0Update, CR0UpdateAck, CPSRUpdate, CPSRUpdateAck;
    logic [15:0] PWDATAIn;
    logic        SSPCR0Wr, SSPCR1Wr, SSPCPSRWr, SSPIMSCWr, SSPICRWr, SSPDMACRWr;
    logic        CfgBusy, CfgDone, CfgErr;

    ssp_cfg_sequencer #(.ACK_TIMEOUT(TMO), .TMO_W(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .CfgStart(CfgStart),
        .CfgCR0(CfgCR0), .CfgCR1(CfgCR1), .CfgCPSR(CfgCPSR),
        .CfgIMSC(CfgIMSC), .CfgDMACR(CfgDMACR),
        .HostWrReq(HostWrReq), .HostSel(HostSel), .HostWData(HostWData),
        .HostWrGnt(HostWrGnt),
        .CR0Update(CR0Update), .CR0UpdateAck(CR0UpdateAck),
        .CPSRUpdate(CPSRUpdate), .CPSRUpdateAck(CPSRUpdateAck),
        .PWDATAIn(PWDATAIn),
        .SSPCR0Wr(SSPCR0Wr), .SSPCR1Wr(SSPCR1Wr), .SSPCPSRWr(SSPCPSRWr),
        .SSPIMSCWr(SSPIMSCWr), .SSPICRWr(SSPICRWr), .SSPDMACRWr(SSPDMACRWr),
        .CfgBusy(CfgBusy), .CfgDone(CfgDone), .CfgErr(CfgErr)
    );

    always #5 PCLK = ~PCLK;

    // Register-core model: strobes toggle Update, Ack follows after dly cycles of pending.
    logic core_cr0 = 1'b0, core_cpsr = 1'b0, poke_cr0 = 1'b0, poke_cpsr = 1'b0;
    logic ack_cr0 = 1'b0, ack_cpsr = 1'b0, hold_cr0 = 1'b0, hold_cpsr = 1'b0;
    int   cnt_cr0 = 0, cnt_cpsr = 0, dly_cr0 = 3, dly_cpsr = 3;
    int   hold_until_cr0 = 0, cyc = 0;

    assign CR0Update     = core_cr0 ^ poke_cr0;
    assign CR0UpdateAck  = ack_cr0;
    assign CPSRUpdate    = core_cpsr ^ poke_cpsr;
    assign CPSRUpdateAck = ack_cpsr;

    logic cr0_pend, cpsr_pend;
    assign cr0_pend  = CR0Update ^ CR0UpdateAck;
    assign cpsr_pend = CPSRUpdate ^ CPSRUpdateAck;

    always @(posedge PCLK) begin
        cyc <= cyc + 1;
        if (SSPCR0Wr)  core_cr0  <= ~core_cr0;
        if (SSPCPSRWr) core_cpsr <= ~core_cpsr;
        if (cr0_pend && !hold_cr0 && !(cyc < hold_until_cr0)) begin
            if (cnt_cr0 + 1 >= dly_cr0) begin ack_cr0 <= ~ack_cr0; cnt_cr0 <= 0; end
            else cnt_cr0 <= cnt_cr0 + 1;
        end
        if (cpsr_pend && !hold_cpsr) begin
            if (cnt_cpsr + 1 >= dly_cpsr) begin ack_cpsr <= ~ack_cpsr; cnt_cpsr <= 0; end
            else cnt_cpsr <= cnt_cpsr + 1;
        end
    end

    logic [5:0] stb;
    assign stb = {SSPDMACRWr, SSPICRWr, SSPIMSCWr, SSPCPSRWr, SSPCR1Wr, SSPCR0Wr};

    int onehot_viol = 0;
    always @(negedge PCLK) begin
        if ($countones(stb) > 1) onehot_viol <= onehot_viol + 1;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_pw  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge PCLK);
        #1;
    endtask

    task automatic host_write(input logic [2:0] sel, input logic [15:0] data);
        logic       e_gnt;
        logic [5:0] e_stb;
        HostWrReq = 1'b1; HostSel = sel; HostWData = data;
        @(negedge PCLK);
        e_gnt = !(((sel == 3'd0) && cr0_pend) || ((sel == 3'd2) && cpsr_pend));
        check("host_gnt", 32'(HostWrGnt), 32'(e_gnt));
        next();
        HostWrReq = 1'b0;
        @(negedge PCLK);
        e_stb = '0;
        if (e_gnt && (sel < 3'd6)) begin
            e_stb  = 6'(1 << sel);
            exp_pw = data;
        end
        check("host_stb", 32'(stb), 32'(e_stb));
        check("host_pw", 32'(PWDATAIn), 32'(exp_pw));
        next();
        check("host_stb_once", 32'(stb), 32'(0));
    endtask

    task automatic wait_pend_clear();
        hold_cr0 = 1'b0; hold_cpsr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!cr0_pend && !cpsr_pend) break;
            next();
        end
        check("pend_clear", 32'(cr0_pend | cpsr_pend), 32'(0));
    endtask

    task automatic run_seq(input logic [15:0] cr0, input logic [6:0] cr1, input logic [6:0] cpsr,
                           input logic [3:0] imsc, input logic [1:0] dmacr,
                           input bit with_host, input bit exp_err);
        logic [21:0] eq[$];
        logic [21:0] gq[$];
        logic [21:0] last;
        int n_done, n_errp, cpsr_cyc, err_cyc;
        bit ended;
        n_done = 0; n_errp = 0; cpsr_cyc = 0; err_cyc = 0; ended = 0;
        eq.push_back({6'b000010, 16'(cr1 & 7'h7D)});
        eq.push_back({6'b000001, cr0});
        eq.push_back({6'b000100, 16'({cpsr, 1'b0})});
        if (!exp_err) begin
            eq.push_back({6'b001000, 16'(imsc)});
            eq.push_back({6'b100000, 16'(dmacr)});
            eq.push_back({6'b010000, 16'h0003});
            eq.push_back({6'b000010, 16'(cr1)});
        end
        CfgStart = 1'b1; CfgCR0 = cr0; CfgCR1 = cr1; CfgCPSR = cpsr;
        CfgIMSC = imsc; CfgDMACR = dmacr;
        HostWrReq = with_host; HostSel = 3'($urandom_range(0, 7)); HostWData = 16'($urandom);
        @(negedge PCLK);
        if (with_host) check("start_gnt", 32'(HostWrGnt), 32'(0));
        next();
        CfgStart = 1'b0; HostWrReq = 1'b0;
        CfgCR0 = 16'($urandom); CfgCR1 = 7'($urandom); CfgCPSR = 7'($urandom);
        CfgIMSC = 4'($urandom); CfgDMACR = 2'($urandom);
        for (int i = 0; i < 200; i++) begin
            @(negedge PCLK);
            if (HostWrReq) check("busy_gnt", 32'(HostWrGnt), 32'(0));
            if (stb != 6'd0) begin
                gq.push_back({stb, PWDATAIn});
                if (stb == 6'b000100) cpsr_cyc = cyc;
            end
            if (CfgDone) begin
                n_done++; ended = 1;
                check("done_busy", 32'(CfgBusy), 32'(1));
            end else if (CfgErr) begin
                n_errp++; ended = 1; err_cyc = cyc;
                check("err_busy", 32'(CfgBusy), 32'(0));
            end else begin
                check("busy", 32'(CfgBusy), 32'(1));
            end
            if (ended) break;
            next();
            if (with_host) begin
                HostWrReq = 1'($urandom_range(0, 1));
                HostSel   = 3'($urandom_range(0, 7));
            end
        end
        check("seq_end", 32'(ended), 32'(1));
        next();
        HostWrReq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            if (i == 0) check("post_busy", 32'(CfgBusy), 32'(0));
            if (stb != 6'd0) gq.push_back({stb, PWDATAIn});
            if (CfgDone) n_done++;
            if (CfgErr) n_errp++;
            next();
        end
        check("done_cnt", 32'(n_done), exp_err ? 32'(0) : 32'(1));
        check("err_cnt", 32'(n_errp), exp_err ? 32'(1) : 32'(0));
        if (exp_err && ended) check("err_lat", 32'(err_cyc - cpsr_cyc), 32'(TMO));
        check("seq_len", 32'(gq.size()), 32'(eq.size()));
        for (int i = 0; i < eq.size() && i < gq.size(); i++)
            check($sformatf("seq_wr%0d", i), 32'(gq[i]), 32'(eq[i]));
        last   = eq[eq.size() - 1];
        exp_pw = last[15:0];
        check("seq_pw", 32'(PWDATAIn), 32'(exp_pw));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK);
            check("rst_stb", 32'(stb), 32'(0));
            check("rst_pw", 32'(PWDATAIn), 32'(0));
            check("rst_busy", 32'(CfgBusy), 32'(0));
            next();
        end

        host_write(3'd3, 16'h000F);

        dly_cr0 = 3; dly_cpsr = 3;
        run_seq(16'h01C7, 7'h02, 7'h01, 4'hA, 2'h3, 1'b1, 1'b0);
        wait_pend_clear();

        // CR0 host write held off while pending; other registers still granted.
        hold_cr0 = 1'b1; poke_cr0 = ~poke_cr0;
        HostWrReq = 1'b1; HostSel = 3'd0; HostWData = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("cr0_held_gnt", 32'(HostWrGnt), 32'(0));
            check("cr0_held_stb", 32'(stb), 32'(0));
            next();
        end
        host_write(3'd1, 16'h0055);
        HostWrReq = 1'b1; HostSel = 3'd0; HostWData = 16'h1234;
        hold_cr0 = 1'b0;
        begin
            bit got;
            got = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge PCLK);
                check("cr0_gnt", 32'(HostWrGnt), 32'(!cr0_pend));
                if (HostWrGnt) begin got = 1; break; end
                next();
            end
            check("cr0_gnt_seen", 32'(got), 32'(1));
            next();
            HostWrReq = 1'b0;
            @(negedge PCLK);
            if (got) exp_pw = 16'h1234;
            check("cr0_host_stb", 32'(stb), got ? 32'(1) : 32'(0));
            check("cr0_host_pw", 32'(PWDATAIn), 32'(exp_pw));
            next();
        end
        wait_pend_clear();

        // CPSR ack withheld: sequence aborts with SSE left disabled.
        hold_cpsr = 1'b1;
        run_seq(16'h0F0F, 7'h06, 7'h22, 4'h5, 2'h1, 1'b0, 1'b1);
        wait_pend_clear();

        // Reset asserted while the sequence is waiting on the CR0 handshake.
        hold_cr0 = 1'b1;
        CfgStart = 1'b1; CfgCR0 = 16'hBEEF; CfgCR1 = 7'h7F;
        next();
        CfgStart = 1'b0;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge PCLK);
                if (SSPCR0Wr) begin seen = 1; break; end
                next();
            end
            check("rst_mid_cr0", 32'(seen), 32'(1));
        end
        next();
        PRESETn = 1'b0;
        next();
        PRESETn = 1'b1;
        exp_pw = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            check("rstmid_stb", 32'(stb), 32'(0));
            check("rstmid_busy", 32'(CfgBusy), 32'(0));
            check("rstmid_flags", 32'({CfgDone, CfgErr}), 32'(0));
            check("rstmid_pw", 32'(PWDATAIn), 32'(0));
            next();
        end
        wait_pend_clear();

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                dly_cr0  = $urandom_range(1, 3);
                dly_cpsr = $urandom_range(1, 3);
                if ($urandom_range(0, 1) == 1) begin
                    poke_cr0 = ~poke_cr0;
                    hold_until_cr0 = cyc + 4;
                end
                run_seq(16'($urandom), 7'($urandom), 7'($urandom), 4'($urandom), 2'($urandom),
                        1'b1, 1'b0);
            end else begin
                case ($urandom_range(0, 3))
                    0: begin hold_cr0 = 1'b1; poke_cr0 = ~poke_cr0; end
                    1: begin hold_cpsr = 1'b1; poke_cpsr = ~poke_cpsr; end
                    default: ;
                endcase
                host_write(3'($urandom_range(0, 7)), 16'($urandom));
            end
            wait_pend_clear();
        end

        check("onehot", 32'(onehot_viol), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
